// File: rtl/count_display_driver.sv
// Converts a 0..31 counter value to tens/ones digits with a subtract-by-10 FSM
// and scans them onto a 2-digit multiplexed 7-segment display.
module count_display_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] value,
  output logic       busy,
  output logic [1:0] tens,
  output logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] an
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam int PRE_W = 20;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  state_t     state, state_nx;
  logic [4:0] shadow, shadow_nx;
  logic [4:0] work, work_nx;
  logic [1:0] tcnt, tcnt_nx;
  logic [1:0] tens_nx;
  logic [3:0] ones_nx;

  logic [PRE_W-1:0] prescaler;
  logic             digit_sel;
  logic [6:0]       seg_raw;
  logic [1:0]       an_raw;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    seg_pol = ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [1:0] an_pol(input logic [1:0] a);
    an_pol = ACTIVE_LOW ? ~a : a;
  endfunction

  // Conversion FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shadow <= 5'd0;
      work   <= 5'd0;
      tcnt   <= 2'd0;
      tens   <= 2'd0;
      ones   <= 4'd0;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      work   <= work_nx;
      tcnt   <= tcnt_nx;
      tens   <= tens_nx;
      ones   <= ones_nx;
    end
  end

  // Conversion FSM: next state; tens/ones commit together at the end of CONV
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    work_nx   = work;
    tcnt_nx   = tcnt;
    tens_nx   = tens;
    ones_nx   = ones;
    case (state)
      IDLE: begin
        if (value != shadow) begin
          shadow_nx = value;
          work_nx   = value;
          tcnt_nx   = 2'd0;
          state_nx  = CONV;
        end
      end
      CONV: begin
        if (work >= 5'd10) begin
          work_nx = work - 5'd10;
          tcnt_nx = tcnt + 2'd1;
        end else begin
          tens_nx  = tcnt;
          ones_nx  = work[3:0];
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CONV);

  // Scan prescaler and digit select
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digit_sel <= 1'b0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    if (digit_sel) begin
      an_raw  = 2'b10;
      seg_raw = (BLANK_LZ && tens == 2'd0) ? 7'h00 : enc({2'b00, tens});
    end else begin
      an_raw  = 2'b01;
      seg_raw = enc(ones);
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= seg_pol(7'h00);
      an  <= an_pol(2'b00);
    end else begin
      seg <= seg_pol(seg_raw);
      an  <= an_pol(an_raw);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: expected digit commits are queued by
// the stimulus and checked by a monitor at each end of conversion.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] value;
  logic       busy, busy2;
  logic [1:0] tens, tens2;
  logic [3:0] ones, ones2;
  logic [6:0] seg, seg2;
  logic [1:0] an, an2;

  int checks = 0;
  int failures = 0;
  logic [5:0] expq[$];

  always #5 clk = ~clk;

  count_display_driver #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .busy(busy),
    .tens(tens), .ones(ones), .seg(seg), .an(an)
  );

  count_display_driver #(.SCAN_DIV(3), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut2 (
    .clk(clk), .reset(reset), .value(value), .busy(busy2),
    .tens(tens2), .ones(ones2), .seg(seg2), .an(an2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int t, input int o);
    expq.push_back({t[1:0], o[3:0]});
  endtask

  // Monitor: a busy high->low transition outside reset is a digit commit
  initial begin
    logic prev_busy;
    logic [5:0] e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset === 1'b1) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && busy === 1'b0) begin
          if (expq.size() == 0) begin
            check("unexpected_commit", {tens, ones}, 6'h3F);
          end else begin
            e = expq.pop_front();
            check("commit_digits", {tens, ones}, e);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Returns number of busy cycles of the next conversion, -1 on timeout
  task automatic run_conv(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) return;
    end
    n = -1;
  endtask

  task automatic check_slot(input bit second, input logic [1:0] an_want,
                            input logic [6:0] seg_want, input string name);
    logic [1:0] a;
    logic [6:0] s;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = second ? an2 : an;
      s = second ? seg2 : seg;
      if (a == an_want) begin
        check(name, s, seg_want);
        return;
      end
    end
    check({name, "_timeout"}, a, an_want);
  endtask

  task automatic check_period(input int want);
    logic [1:0] last;
    int n;
    n = -1;
    @(negedge clk);
    last = an;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an != last) begin
        last = an;
        n = 0;
        break;
      end
    end
    if (n == 0) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        n++;
        if (an != last) break;
      end
    end
    check("scan_period", n, want);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    value = 5'd0;

    // 1: reset state
    @(negedge clk);
    check("reset_seg", seg, 7'h7F);
    check("reset_an", an, 2'b11);
    check("reset_busy", busy, 0);
    check("reset_seg_ah", seg2, 7'h00);
    check("reset_an_ah", an2, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check("reset_digits", {tens, ones}, 0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_an", an, 2'b10);
    check("idle_seg", seg, 7'h40);
    check("idle_busy", busy, 0);

    // 2: 0 -> 29
    value = 5'd29;
    push(2, 9);
    run_conv(n);
    check("busy_len_29", n, 3);
    check("digits_29", {tens, ones}, {2'd2, 4'd9});
    check_slot(0, 2'b10, 7'h10, "ones_29");
    check_slot(0, 2'b01, 7'h24, "tens_29");

    // 3: change during CONV is picked up afterwards
    value = 5'd5;
    push(0, 5);
    run_conv(n);
    check("busy_len_5", n, 1);
    value = 5'd25;
    push(2, 5);
    @(negedge clk);
    value = 5'd26;
    push(2, 6);
    run_conv(n);
    check("busy_rest_25", n, 2);
    run_conv(n);
    check("busy_len_26", n, 3);
    check("digits_26", {tens, ones}, {2'd2, 4'd6});

    // 4: scan rate and leading-zero blanking
    value = 5'd7;
    push(0, 7);
    run_conv(n);
    check("digits_7", {tens, ones}, {2'd0, 4'd7});
    check_period(4);
    check_slot(0, 2'b10, 7'h78, "ones_7");
    check_slot(0, 2'b01, 7'h7F, "tens_7_blank");

    // 5: max value, then unblanked zero on the active-high instance
    value = 5'd31;
    push(3, 1);
    run_conv(n);
    check("busy_len_31", n, 4);
    check("digits_31", {tens, ones}, {2'd3, 4'd1});
    check_slot(0, 2'b10, 7'h79, "ones_31");
    check_slot(0, 2'b01, 7'h30, "tens_31");
    value = 5'd3;
    push(0, 3);
    run_conv(n);
    check("digits_3", {tens, ones}, {2'd0, 4'd3});
    check_slot(0, 2'b01, 7'h7F, "tens_3_blank");
    check_slot(1, 2'b10, 7'h3F, "tens_3_noblank");
    check_slot(1, 2'b01, 7'h4F, "ones_3_ah");

    // 6: reset during the second CONV cycle
    value = 5'd29;
    @(negedge clk);
    check("busy_conv1", busy, 1);
    @(negedge clk);
    check("busy_conv2", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_digits", {tens, ones}, 0);
    reset = 1'b0;
    push(2, 9);
    run_conv(n);
    check("busy_len_reconv", n, 3);
    check("digits_reconv", {tens, ones}, {2'd2, 4'd9});

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
